// File: rtl/fwd_scoreboard.sv
// Issue-stage RAW/WAW scoreboard with forwarding-select generation.
// Define FWD_SB_PERF_EN to build the saturating stall-cycle counter.
module fwd_scoreboard #(
  parameter int NUM_SRC = 2,
  parameter int NUM_FWD = 2,
  parameter int LAT_W   = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 issue_valid,
  input  logic [NUM_SRC*5-1:0] issue_rs,
  input  logic [4:0]           issue_rd,
  input  logic                 issue_wb_en,
  input  logic [LAT_W-1:0]     issue_lat,
  input  logic                 flush,
  input  logic [NUM_FWD-1:0]   fwd_wb_en,
  input  logic [NUM_FWD*5-1:0] fwd_rd,
  output logic                 stall,
  output logic                 issue_accept,
  output logic [NUM_SRC*2-1:0] fwd_sel,
  output logic                 busy,
  output logic [31:0]          perf_stall_cycles
);

  logic [LAT_W-1:0] cnt_q [1:31];
  logic [LAT_W-1:0] cnt_v [32];
  logic             raw;
  logic             waw;
  logic             load;
  logic [4:0]       rs;
  logic [4:0]       frd;

  // x0 never has an entry; a zero view keeps lookups uniform
  always_comb begin
    cnt_v[0] = '0;
    for (int r = 1; r < 32; r++) cnt_v[r] = cnt_q[r];
  end

  always_comb begin
    raw = 1'b0;
    rs  = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      rs = issue_rs[5*i +: 5];
      if (rs != 5'd0 && cnt_v[rs] != '0) raw = 1'b1;
    end
  end

  assign waw = issue_wb_en && issue_rd != 5'd0
            && cnt_v[issue_rd] > issue_lat;

  assign stall        = issue_valid & (raw | waw);
  assign issue_accept = issue_valid & ~stall & ~flush;
  assign load         = issue_accept & issue_wb_en
                      & (issue_rd != 5'd0) & (issue_lat != '0);

  // walk oldest to youngest so the youngest match is the one kept
  always_comb begin
    fwd_sel = '0;
    frd     = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      for (int k = NUM_FWD - 1; k >= 0; k--) begin
        frd = fwd_rd[5*k +: 5];
        if (fwd_wb_en[k] && frd != 5'd0
            && frd == issue_rs[5*i +: 5])
          fwd_sel[2*i +: 2] = 2'(k + 1);
      end
    end
  end

  for (genvar r = 1; r < 32; r++) begin : g_cnt
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
        cnt_q[r] <= '0;
      else if (load && issue_rd == 5'(r))
        cnt_q[r] <= issue_lat;
      else if (cnt_q[r] != '0)
        cnt_q[r] <= cnt_q[r] - 1'b1;
    end
  end

  always_comb begin
    busy = 1'b0;
    for (int r = 1; r < 32; r++)
      if (cnt_q[r] != '0) busy = 1'b1;
  end

`ifdef FWD_SB_PERF_EN
  logic [31:0] perf_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      perf_q <= '0;
    else if (stall && perf_q != 32'hFFFF_FFFF)
      perf_q <= perf_q + 32'd1;
  end

  assign perf_stall_cycles = perf_q;
`else
  assign perf_stall_cycles = 32'd0;
`endif

endmodule

// File: doc/fwd_scoreboard.md
FWD_SCOREBOARD -- requirements
Module: fwd_scoreboard

Interface
REQ-001 SHALL have parameter NUM_SRC, default 2, range 1..4: number of source operands checked per issue.
REQ-002 SHALL have parameter NUM_FWD, default 2, range 1..3: number of forwarding stages; index 0 is youngest (MEM), 1 is next (WB).
REQ-003 SHALL have parameter LAT_W, default 3: width of the per-register pending-latency counter.
REQ-004 clk  input  1  sole clock; all state on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 issue_valid  input  1  instruction in decode requests issue.
REQ-007 issue_rs  input  NUM_SRC*5  source register indices; src i at bits [5i+4:5i].
REQ-008 issue_rd  input  5  destination register index.
REQ-009 issue_wb_en  input  1  instruction writes issue_rd.
REQ-010 issue_lat  input  LAT_W  extra cycles before the result reaches the forwarding network (ALU 0, load 1, mul/div more).
REQ-011 flush  input  1  cancels the instruction currently at issue.
REQ-012 fwd_wb_en  input  NUM_FWD  per-stage write enable.
REQ-013 fwd_rd  input  NUM_FWD*5  per-stage destination index, stage k at [5k+4:5k].
REQ-014 stall  output  1  issue blocked this cycle.
REQ-015 issue_accept  output  1  issue_valid & ~stall & ~flush.
REQ-016 fwd_sel  output  NUM_SRC*2  per-source operand select: 0 register file, k+1 forward from stage k.
REQ-017 busy  output  1  at least one scoreboard counter nonzero.
REQ-018 perf_stall_cycles  output  32  stall-cycle count (REQ-032).

Function
REQ-019 SHALL hold one LAT_W-bit counter cnt[r] per register r=1..31; register 0 has no entry and always reads 0.
REQ-020 Each cycle, every nonzero cnt[r] SHALL decrement by 1.
REQ-021 On issue_accept with issue_wb_en=1, issue_rd!=0 and issue_lat!=0, cnt[issue_rd] SHALL load issue_lat, overriding that cycle's decrement.
REQ-022 stall SHALL be combinational: issue_valid & (RAW | WAW).
REQ-023 RAW SHALL be asserted when any source i with issue_rs[i]!=0 has cnt[issue_rs[i]]!=0.
REQ-024 WAW SHALL be asserted when issue_wb_en, issue_rd!=0 and cnt[issue_rd] > issue_lat.
REQ-025 flush SHALL suppress issue_accept and any scoreboard load; counters SHALL continue decrementing because older instructions still complete.
REQ-026 fwd_sel[i] SHALL be k+1 for the lowest k with fwd_wb_en[k], fwd_rd[k]==issue_rs[i] and fwd_rd[k]!=0; otherwise 0. The younger stage wins on a multi-stage match.
REQ-027 fwd_sel SHALL be valid whenever issue_valid=1, independent of stall.
REQ-028 An issue with issue_lat=0 SHALL not touch the scoreboard; dependents rely only on fwd_sel.
REQ-029 busy SHALL be the OR of all cnt[r]!=0, registered-state based, with no dependence on issue inputs.

Reset
REQ-030 While rst_n=0, all cnt[r] SHALL be 0 and perf_stall_cycles SHALL be 0; busy=0 immediately.
REQ-031 Reset asserted mid-operation SHALL discard all pending entries; the first cycle after release SHALL see stall=0 for any issue.

Configuration
REQ-032 With FWD_SB_PERF_EN defined, perf_stall_cycles SHALL increment by 1 on each cycle with stall=1 and saturate at 32'hFFFF_FFFF. Without the macro, the port SHALL still exist, driven constant 0, and no counter flops SHALL be inferred.

Verification
REQ-033 Load-use: issue rd=5, lat=1; next cycle issue rs1=5 -> stall=1 for 1 cycle, then accept with fwd_sel[0] per the stage inputs.
REQ-034 Multi-cycle: issue rd=7, lat=4; dependent on x7 -> stall for 4 cycles, busy=1 throughout, busy=0 after.
REQ-035 WAW: rd=3 lat=5 pending with cnt=4; issue rd=3 lat=1 -> stall until cnt<=1.
REQ-036 Forward priority: fwd_rd={9,9}, both wb_en=1, rs1=9 -> fwd_sel[0]=1; rs=0 with fwd_rd[0]=0 -> fwd_sel=0.
REQ-037 Flush: issue rd=4 lat=3 with flush=1 -> no entry, later read of x4 not stalled; reset mid-countdown clears cnt.
REQ-038 With FWD_SB_PERF_EN: 10 stall cycles -> perf_stall_cycles=10; without the macro -> 0.
